// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if: request/strobe bundle between the instruction decoder,
// the stack sequencer and the stack pointer / memory.
//   master (decoder side): drives start, op, load_val; observes everything else.
//   slave  (sequencer)   : consumes start, op, load_val; drives
//     busy/done/err status, the active-low SP controls (sp_outn, sp_loadn,
//     sp_cupn, sp_cdownn), memory strobes (mem_wen, mem_oen), byte_hi,
//     abus_drv and the 16-bit shadow SP (sp_shadow).
interface stack_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [15:0] load_val;
  logic        busy;
  logic        done;
  logic        err;
  logic        sp_outn;
  logic        sp_loadn;
  logic        sp_cupn;
  logic        sp_cdownn;
  logic        mem_wen;
  logic        mem_oen;
  logic        byte_hi;
  logic        abus_drv;
  logic [15:0] sp_shadow;

  modport master (
    output start, op, load_val,
    input  busy, done, err, sp_outn, sp_loadn, sp_cupn, sp_cdownn,
           mem_wen, mem_oen, byte_hi, abus_drv, sp_shadow
  );

  modport slave (
    input  start, op, load_val,
    output busy, done, err, sp_outn, sp_loadn, sp_cupn, sp_cdownn,
           mem_wen, mem_oen, byte_hi, abus_drv, sp_shadow
  );
endinterface

// File: rtl/stack_sequencer.sv
// stack_sequencer: runs complete stack operations (PUSH8, POP8, PUSH16, POP16,
// LOAD, STORE) by sequencing the stack pointer's active-low controls and the
// memory strobes, one step per clock, and keeps a shadow copy of SP.
// Ports:
//   clk    - system clock, all state on rising edge
//   resetn - asynchronous active-low reset
//   bus    - stack_sequencer_if.slave (request in, status/strobes/shadow out)
// Optional feature: define STACK_SEQ_BOUNDS_EN to abort pushes/pops that would
// leave the SP_MIN..SP_TOP window (checked against the shadow at acceptance).
// All outputs are registered; strobes are decoded from the next step.
module stack_sequencer
`ifdef STACK_SEQ_BOUNDS_EN
  #(
    parameter logic [15:0] SP_MIN = 16'h0100,
    parameter logic [15:0] SP_TOP = 16'h0200
  )
`endif
  (
    input  logic clk,
    input  logic resetn,
    stack_sequencer_if.slave bus
  );

  typedef enum logic [2:0] {
    S_IDLE, S_DEC, S_WR, S_INC, S_RD, S_LOAD, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d, nxt_idx;
  logic [2:0]  op_q, op_d;
  logic [15:0] ld_q, ld_d;
  logic [15:0] shadow_q, shadow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        bh_q, bh_d;
  logic        outn_q, loadn_q, cupn_q, cdownn_q, wen_q, oen_q, abus_q;
  logic        fault;

  // Step kind for a given op and step index.
  function automatic state_t step_state(input logic [2:0] op, input logic [1:0] idx);
    case (op)
      3'd0:    step_state = (idx == 2'd0) ? S_DEC : S_WR;
      3'd1:    step_state = (idx == 2'd0) ? S_RD : S_INC;
      3'd2:    step_state = idx[0] ? S_WR : S_DEC;
      3'd3:    step_state = idx[0] ? S_INC : S_RD;
      3'd4:    step_state = S_LOAD;
      3'd5:    step_state = S_OUT;
      default: step_state = S_IDLE;
    endcase
  endfunction

  // PUSH16 writes the high byte first (step 1); POP16 reads it second (step 2).
  function automatic logic step_hi(input logic [2:0] op, input logic [1:0] idx);
    step_hi = ((op == 3'd2) && (idx == 2'd1)) || ((op == 3'd3) && (idx == 2'd2));
  endfunction

  function automatic logic [1:0] last_step(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: last_step = 2'd1;
      3'd2, 3'd3: last_step = 2'd3;
      default:    last_step = 2'd0;
    endcase
  endfunction

`ifdef STACK_SEQ_BOUNDS_EN
  // 17-bit unsigned compare so an SP near 0 or 0xFFFF cannot wrap past a bound.
  function automatic logic bounds_fault(input logic [2:0] op, input logic [15:0] sp);
    logic [16:0] sp17;
    sp17 = {1'b0, sp};
    case (op)
      3'd0:    bounds_fault = sp17 < ({1'b0, SP_MIN} + 17'd1);
      3'd2:    bounds_fault = sp17 < ({1'b0, SP_MIN} + 17'd2);
      3'd1:    bounds_fault = (sp17 + 17'd1) > {1'b0, SP_TOP};
      3'd3:    bounds_fault = (sp17 + 17'd2) > {1'b0, SP_TOP};
      default: bounds_fault = 1'b0;
    endcase
  endfunction

  assign fault = bounds_fault(bus.op, shadow_d);
`else
  assign fault = 1'b0;
`endif

  // Shadow follows the real SP: it changes at the edge that ends the step,
  // which is when the counter/load actually takes effect. Bounds checks use
  // this post-edge value so back-to-back ops see the up-to-date SP.
  always_comb begin
    shadow_d = shadow_q;
    case (state_q)
      S_DEC:   shadow_d = shadow_q - 16'd1;
      S_INC:   shadow_d = shadow_q + 16'd1;
      S_LOAD:  shadow_d = ld_q;
      default: shadow_d = shadow_q;
    endcase
  end

  assign nxt_idx = step_q + 2'd1;

  // Next step selection. The done cycle counts as idle for acceptance.
  always_comb begin
    state_d = S_IDLE;
    step_d  = step_q;
    op_d    = op_q;
    ld_d    = ld_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    bh_d    = 1'b0;
    if (busy_q && !done_q) begin
      busy_d  = 1'b1;
      step_d  = nxt_idx;
      state_d = step_state(op_q, nxt_idx);
      bh_d    = step_hi(op_q, nxt_idx);
      done_d  = (nxt_idx == last_step(op_q));
    end else if (bus.start) begin
      busy_d = 1'b1;
      if ((bus.op > 3'd5) || fault) begin
        // Single strobe-free cycle flagged as an error.
        done_d = 1'b1;
        err_d  = 1'b1;
      end else begin
        op_d    = bus.op;
        step_d  = 2'd0;
        ld_d    = bus.load_val;
        state_d = step_state(bus.op, 2'd0);
        bh_d    = step_hi(bus.op, 2'd0);
        done_d  = (last_step(bus.op) == 2'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      step_q   <= 2'd0;
      op_q     <= 3'd0;
      ld_q     <= 16'h0000;
      shadow_q <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      bh_q     <= 1'b0;
      outn_q   <= 1'b1;
      loadn_q  <= 1'b1;
      cupn_q   <= 1'b1;
      cdownn_q <= 1'b1;
      wen_q    <= 1'b1;
      oen_q    <= 1'b1;
      abus_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      op_q     <= op_d;
      ld_q     <= ld_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      bh_q     <= bh_d;
      outn_q   <= !((state_d == S_WR) || (state_d == S_RD) || (state_d == S_OUT));
      loadn_q  <= (state_d != S_LOAD);
      cupn_q   <= (state_d != S_INC);
      cdownn_q <= (state_d != S_DEC);
      wen_q    <= (state_d != S_WR);
      oen_q    <= (state_d != S_RD);
      abus_q   <= (state_d == S_OUT);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.sp_outn   = outn_q;
  assign bus.sp_loadn  = loadn_q;
  assign bus.sp_cupn   = cupn_q;
  assign bus.sp_cdownn = cdownn_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_oen   = oen_q;
  assign bus.byte_hi   = bh_q;
  assign bus.abus_drv  = abus_q;
  assign bus.sp_shadow = shadow_q;

endmodule
